// File: rtl/hwpe_stream_package.sv
// Shared definitions for the HWPE stream TCDM blocks: responder FSM states and
// the data word returned for out-of-range reads.
package hwpe_stream_package;

    typedef enum logic [0:0] {
        TCDM_READY = 1'b0,
        TCDM_STALL = 1'b1
    } tcdm_resp_state_e;

    localparam logic [31:0] TCDM_OOR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// 32-bit TCDM request/response bundle with master/slave views and an optional
// protocol check on r_valid.
interface hwpe_stream_intf_tcdm #(
    parameter bit BYPASS_TRVR_ASSERT = 1'b0
) (
    input logic clk
);
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (
        output req, add, wen, be, data,
        input  gnt, r_data, r_valid
    );

    modport slave (
        input  req, add, wen, be, data,
        output gnt, r_data, r_valid
    );

    // r_valid is only legal in the cycle right after a granted read.
    generate
        if (!BYPASS_TRVR_ASSERT) begin : gen_trvr_assert
            rvalid_after_read : assert property (@(posedge clk) r_valid |-> $past(req & gnt & wen));
        end
    endgenerate

endinterface

// File: rtl/hwpe_stream_tcdm_responder_mem.sv
// Word-addressed 32-bit memory with byte-enabled write and a registered read port.
module hwpe_stream_tcdm_responder_mem #(
    parameter  int unsigned NB_WORDS = 256,
    localparam int unsigned ADDR_W   = $clog2(NB_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [NB_WORDS];
    logic [31:0] rdata_q;

    // NOTE: the array is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/hwpe_stream_tcdm_responder.sv
// TCDM responder: grants requests with an optional fixed stall after each grant,
// serves them from a local memory and flags out-of-range accesses.
module hwpe_stream_tcdm_responder
    import hwpe_stream_package::*;
#(
    parameter int unsigned NB_WORDS     = 256,
    parameter int unsigned STALL_CYCLES = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    hwpe_stream_intf_tcdm.slave tcdm,
    output logic                err_o
);

    localparam int unsigned ADDR_W = $clog2(NB_WORDS);
    localparam int unsigned CNT_W  = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;

    tcdm_resp_state_e  state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] word_idx;
    logic              oor, gnt, hs, rd_hs, wr_en, rd_en;
    logic              r_valid_q, r_valid_d;
    logic              err_q, err_d;
    logic              rd_oor_q, rd_oor_d;
    logic [31:0]       mem_rdata;
    logic              unused_add_lsb;

    assign word_idx       = tcdm.add[ADDR_W+1:2];
    assign oor            = |tcdm.add[31:ADDR_W+2];
    assign unused_add_lsb = ^tcdm.add[1:0];

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        case (state_q)
            TCDM_READY: begin
                gnt = tcdm.req;
                if (tcdm.req && (STALL_CYCLES > 0)) begin
                    state_d = TCDM_STALL;
                    cnt_d   = CNT_W'(STALL_CYCLES);
                end
            end
            TCDM_STALL: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = TCDM_READY;
            end
            default: state_d = TCDM_READY;
        endcase
        if (clear_i) begin
            state_d = TCDM_READY;
            cnt_d   = '0;
            gnt     = 1'b0;
        end
    end

    assign hs        = tcdm.req & gnt;
    assign rd_hs     = hs & tcdm.wen;
    assign wr_en     = hs & ~tcdm.wen & ~oor;
    assign rd_en     = rd_hs & ~oor;
    assign r_valid_d = rd_hs & ~clear_i;
    assign err_d     = hs & oor & ~clear_i;
    // Remembers whether the word on r_data came from an out-of-range read.
    assign rd_oor_d  = rd_hs ? oor : rd_oor_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= TCDM_READY;
            cnt_q     <= '0;
            r_valid_q <= 1'b0;
            err_q     <= 1'b0;
            rd_oor_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            r_valid_q <= r_valid_d;
            err_q     <= err_d;
            rd_oor_q  <= rd_oor_d;
        end
    end

    hwpe_stream_tcdm_responder_mem #(
        .NB_WORDS (NB_WORDS)
    ) i_mem (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (wr_en),
        .re_i    (rd_en),
        .be_i    (tcdm.be),
        .addr_i  (word_idx),
        .wdata_i (tcdm.data),
        .rdata_o (mem_rdata)
    );

    assign tcdm.gnt     = gnt;
    assign tcdm.r_valid = r_valid_q;
    assign tcdm.r_data  = rd_oor_q ? TCDM_OOR_RDATA : mem_rdata;
    assign err_o        = err_q;

endmodule

// File: tb/tb_hwpe_stream_tcdm_responder.sv
// Directed bench for the TCDM responder: one instance without stalls, one with
// STALL_CYCLES=3; read data is predicted into a scoreboard queue at grant time.
module tb_hwpe_stream_tcdm_responder;

    localparam int unsigned NB_WORDS = 256;
    localparam logic [31:0] OOR_BASE = 32'(NB_WORDS * 4);

    logic        clk = 1'b0;
    logic        rst_n0, rst_n3, clear, sel;
    logic        req, wen;
    logic [31:0] add, wdata, rd_exp;
    logic [3:0]  be;
    logic        err0, err3;
    logic        gnt, r_valid, err;
    logic [31:0] r_data;

    logic [31:0] sb_q[$];
    logic [31:0] last_rd [2];
    int          pass_cnt  = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;

    hwpe_stream_intf_tcdm #(.BYPASS_TRVR_ASSERT(1'b0)) tcdm0 (.clk(clk));
    hwpe_stream_intf_tcdm #(.BYPASS_TRVR_ASSERT(1'b0)) tcdm3 (.clk(clk));

    assign tcdm0.req  = req & ~sel;
    assign tcdm0.add  = add;
    assign tcdm0.wen  = wen;
    assign tcdm0.be   = be;
    assign tcdm0.data = wdata;
    assign tcdm3.req  = req & sel;
    assign tcdm3.add  = add;
    assign tcdm3.wen  = wen;
    assign tcdm3.be   = be;
    assign tcdm3.data = wdata;

    assign gnt     = sel ? tcdm3.gnt     : tcdm0.gnt;
    assign r_valid = sel ? tcdm3.r_valid : tcdm0.r_valid;
    assign r_data  = sel ? tcdm3.r_data  : tcdm0.r_data;
    assign err     = sel ? err3          : err0;

    hwpe_stream_tcdm_responder #(
        .NB_WORDS     (NB_WORDS),
        .STALL_CYCLES (0)
    ) dut0 (
        .clk_i   (clk),
        .rst_ni  (rst_n0),
        .clear_i (clear),
        .tcdm    (tcdm0),
        .err_o   (err0)
    );

    hwpe_stream_tcdm_responder #(
        .NB_WORDS     (NB_WORDS),
        .STALL_CYCLES (3)
    ) dut3 (
        .clk_i   (clk),
        .rst_ni  (rst_n3),
        .clear_i (clear),
        .tcdm    (tcdm3),
        .err_o   (err3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // For reads d is the expected word; for writes it is the write data.
    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        req = r;
        wen = w;
        add = a;
        be  = b;
        if (w) rd_exp = d;
        else   wdata  = d;
    endtask

    // Called at a negedge: checks gnt, then the response one edge later.
    task automatic tick(input string tag, input logic exp_gnt);
        logic        rd_hs, err_exp;
        logic [31:0] exp_data;
        #1;
        check({tag, " gnt"}, 32'(gnt), 32'(exp_gnt));
        rd_hs   = exp_gnt & req & wen;
        err_exp = exp_gnt & req & (add >= OOR_BASE);
        if (rd_hs) sb_q.push_back(err_exp ? 32'h0 : rd_exp);
        @(posedge clk);
        #1;
        check({tag, " r_valid"}, 32'(r_valid), 32'(rd_hs));
        check({tag, " err"}, 32'(err), 32'(err_exp));
        if (r_valid && sb_q.size() > 0) begin
            exp_data     = sb_q.pop_front();
            last_rd[sel] = exp_data;
        end
        check({tag, " r_data"}, r_data, last_rd[sel]);
        @(negedge clk);
    endtask

    initial begin
        rst_n0 = 1'b0;
        rst_n3 = 1'b0;
        clear  = 1'b0;
        sel    = 1'b0;
        rd_exp = '0;
        wdata  = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n0 = 1'b1;
        rst_n3 = 1'b1;

        // No-stall instance
        tick("reset_idle", 1'b0);
        drive(1'b1, 1'b0, 32'h10, 4'hF, 32'hA5A5_1234);
        tick("wr_full", 1'b1);
        drive(1'b1, 1'b1, 32'h10, 4'h0, 32'hA5A5_1234);
        tick("rd_full", 1'b1);
        drive(1'b1, 1'b0, 32'h10, 4'b0010, 32'h0000_FF00);
        tick("wr_byte1", 1'b1);
        drive(1'b1, 1'b1, 32'h10, 4'h0, 32'hA5A5_FF34);
        tick("rd_byte1", 1'b1);
        drive(1'b1, 1'b1, 32'h400, 4'h0, 32'h0);
        tick("rd_oor", 1'b1);
        drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        tick("idle_after_oor", 1'b0);
        drive(1'b1, 1'b0, 32'h410, 4'hF, 32'hDEAD_BEEF);
        tick("wr_oor", 1'b1);
        drive(1'b1, 1'b1, 32'h10, 4'h0, 32'hA5A5_FF34);
        tick("rd_after_oor", 1'b1);
        drive(1'b1, 1'b0, 32'h14, 4'b1001, 32'h1122_3344);
        tick("wr_lanes03", 1'b1);
        drive(1'b1, 1'b0, 32'h17, 4'b0110, 32'h5566_7788);
        tick("wr_lanes12", 1'b1);
        drive(1'b1, 1'b1, 32'h15, 4'h0, 32'h1166_7744);
        tick("rd_lanes", 1'b1);
        clear = 1'b1;
        drive(1'b1, 1'b1, 32'h10, 4'h0, 32'hA5A5_FF34);
        tick("clear_hold", 1'b0);
        clear = 1'b0;
        tick("rd_after_clear", 1'b1);

        // STALL_CYCLES=3 instance
        sel = 1'b1;
        drive(1'b1, 1'b0, 32'h20, 4'hF, 32'hCAFE_F00D);
        tick("s3_wr", 1'b1);
        drive(1'b1, 1'b1, 32'h20, 4'h0, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) tick($sformatf("s3_wr_stall%0d", i), 1'b0);
        for (int i = 0; i < 12; i++) tick($sformatf("s3_rd%0d", i), (i % 4) == 0);

        tick("s3_rd_before_rst", 1'b1);
        req    = 1'b0;
        rst_n3 = 1'b0;
        #1;
        check("s3_async_rst r_valid", 32'(r_valid), 32'h0);
        check("s3_async_rst r_data", r_data, 32'h0);
        check("s3_async_rst err", 32'(err), 32'h0);
        @(negedge clk);
        rst_n3     = 1'b1;
        last_rd[1] = 32'h0;
        drive(1'b1, 1'b1, 32'h20, 4'h0, 32'hCAFE_F00D);
        tick("s3_rd_after_rst", 1'b1);
        drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        tick("s3_idle_end", 1'b0);

        check("scoreboard empty", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
